// File: rtl/rx_pkg.sv
// Shared definitions for the receive symbol slicer.
//   - default sample width, oversampling ratio and search window
//   - FSM state encoding for the phase search
//   - accumulator width helper
package rx_pkg;

   localparam int NB_SAMPLE_DEF = 8;
   localparam int OS_DEF        = 4;
   localparam int WINDOW_DEF    = 1024;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_DECIDE = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   // A window of full-scale samples (energy 2^nb_sample each) sums to
   // 2^(nb_sample + clog2(window)), which needs one bit more than that.
   function automatic int acc_width(input int nb_sample, input int window);
      return nb_sample + 1 + $clog2(window);
   endfunction

endpackage

// File: rtl/rx_symbol_slicer_if.sv
// Sample-in / bit-out bundle of the symbol slicer.
//   master: sample source and bit consumer (drives i_en_rx, i_sample_I/Q)
//   slave : the slicer (drives o_rx_bit_I/Q, o_en_rate1)
interface rx_symbol_slicer_if
   import rx_pkg::*;
#(
   parameter int NB_SAMPLE = NB_SAMPLE_DEF
);
   logic                        i_en_rx;
   logic signed [NB_SAMPLE-1:0] i_sample_I;
   logic signed [NB_SAMPLE-1:0] i_sample_Q;
   logic                        o_rx_bit_I;
   logic                        o_rx_bit_Q;
   logic                        o_en_rate1;

   modport master (
      output i_en_rx, i_sample_I, i_sample_Q,
      input  o_rx_bit_I, o_rx_bit_Q, o_en_rate1
   );

   modport slave (
      input  i_en_rx, i_sample_I, i_sample_Q,
      output o_rx_bit_I, o_rx_bit_Q, o_en_rate1
   );
endinterface

// File: rtl/rx_phase_energy.sv
// Per-phase energy accumulators with argmax.
//   clk, i_reset     : clock, async active-low reset
//   i_clear          : zero all accumulators (wins over i_enable)
//   i_enable         : add i_energy into the accumulator selected by i_phase
//   i_phase          : phase of the current sample
//   i_energy         : |I| + |Q| of the current sample
//   o_best_phase     : index of the largest accumulator, lowest index on ties
module rx_phase_energy
   import rx_pkg::*;
#(
   parameter int NB_E     = 9,
   parameter int OS       = OS_DEF,
   parameter int NB_PHASE = $clog2(OS),
   parameter int NB_ACC   = 19
)(
   input  logic                clk,
   input  logic                i_reset,
   input  logic                i_clear,
   input  logic                i_enable,
   input  logic [NB_PHASE-1:0] i_phase,
   input  logic [NB_E-1:0]     i_energy,
   output logic [NB_PHASE-1:0] o_best_phase
);

   logic [NB_ACC-1:0] acc [OS];
   logic [NB_ACC-1:0] best_val;

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < OS; k++) acc[k] <= '0;
      end else if (i_clear) begin
         for (int k = 0; k < OS; k++) acc[k] <= '0;
      end else if (i_enable) begin
         for (int k = 0; k < OS; k++)
            if (i_phase == NB_PHASE'(k)) acc[k] <= acc[k] + NB_ACC'(i_energy);
      end
   end

   // Strict greater-than keeps the earliest index on ties.
   always_comb begin
      best_val     = acc[0];
      o_best_phase = '0;
      for (int k = 1; k < OS; k++) begin
         if (acc[k] > best_val) begin
            best_val     = acc[k];
            o_best_phase = NB_PHASE'(k);
         end
      end
   end

endmodule

// File: rtl/rx_symbol_slicer.sv
// Symbol timing and hard decision ahead of the BER checker.
// Picks one sampling phase out of OS per symbol, slices it to bits and
// strobes o_en_rate1 for one cycle per bit pair.
//   clk, i_reset : clock, async active-low reset
//   rx           : sample in / bits out (slave modport)
//   i_restart    : pulse, restarts the phase search
//   i_phase_sel  : manual phase (only without RX_PHASE_SEARCH_EN)
//   o_phase      : phase used for slicing
//   o_locked     : a search has completed (always 1 out of reset without search)
// Build option: RX_PHASE_SEARCH_EN enables the max-energy phase search.
//
// state   | meaning
// IDLE    | first cycle out of reset, clears the search
// SEARCH  | accumulating WINDOW*OS enabled samples
// DECIDE  | one cycle, loads argmax into o_phase, sets o_locked
// LOCKED  | holds o_phase until i_restart
module rx_symbol_slicer
   import rx_pkg::*;
#(
   parameter int NB_SAMPLE = NB_SAMPLE_DEF,
   parameter int OS        = OS_DEF,
   parameter int NB_PHASE  = $clog2(OS),
   parameter int WINDOW    = WINDOW_DEF
)(
   input  logic                clk,
   input  logic                i_reset,
   rx_symbol_slicer_if.slave   rx,
   input  logic                i_restart,
   input  logic [NB_PHASE-1:0] i_phase_sel,
   output logic [NB_PHASE-1:0] o_phase,
   output logic                o_locked
);

   localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS - 1);

   logic [NB_PHASE-1:0] phase_cnt;
   logic                slice_evt;

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset)
         phase_cnt <= '0;
      else if (rx.i_en_rx)
         phase_cnt <= (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + 1'b1;
   end

   assign slice_evt = rx.i_en_rx && (phase_cnt == o_phase);

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         rx.o_rx_bit_I <= 1'b0;
         rx.o_rx_bit_Q <= 1'b0;
         rx.o_en_rate1 <= 1'b0;
      end else begin
         rx.o_en_rate1 <= slice_evt;
         if (slice_evt) begin
            rx.o_rx_bit_I <= rx.i_sample_I[NB_SAMPLE-1];
            rx.o_rx_bit_Q <= rx.i_sample_Q[NB_SAMPLE-1];
         end
      end
   end

`ifdef RX_PHASE_SEARCH_EN
   localparam int NB_ACC = acc_width(NB_SAMPLE, WINDOW);
   localparam int NB_CNT = $clog2(WINDOW * OS);
   localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(WINDOW * OS - 1);

   logic [1:0]           state;
   logic [NB_CNT-1:0]    smp_cnt;
   logic                 clr;
   logic                 acc_en;
   logic [NB_SAMPLE-1:0] raw_i, raw_q, abs_i, abs_q;
   logic [NB_SAMPLE:0]   energy;
   logic [NB_PHASE-1:0]  best_phase;
   logic                 unused_phase_sel;

   assign unused_phase_sel = ^i_phase_sel;

   // Two's-complement negate of the most negative code yields 2^(N-1),
   // which is exact when read back as unsigned.
   assign raw_i  = rx.i_sample_I;
   assign raw_q  = rx.i_sample_Q;
   assign abs_i  = raw_i[NB_SAMPLE-1] ? (~raw_i + 1'b1) : raw_i;
   assign abs_q  = raw_q[NB_SAMPLE-1] ? (~raw_q + 1'b1) : raw_q;
   assign energy = {1'b0, abs_i} + {1'b0, abs_q};

   assign clr    = (state == ST_IDLE) || i_restart;
   assign acc_en = (state == ST_SEARCH) && rx.i_en_rx;

   rx_phase_energy #(
      .NB_E     (NB_SAMPLE + 1),
      .OS       (OS),
      .NB_PHASE (NB_PHASE),
      .NB_ACC   (NB_ACC)
   ) u_energy (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_clear      (clr),
      .i_enable     (acc_en),
      .i_phase      (phase_cnt),
      .i_energy     (energy),
      .o_best_phase (best_phase)
   );

   // smp_cnt counts enabled samples down to the end of the window, so each
   // phase receives exactly WINDOW samples whatever phase the search started on.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= ST_IDLE;
         smp_cnt  <= '0;
         o_phase  <= '0;
         o_locked <= 1'b0;
      end else if (clr) begin
         state   <= ST_SEARCH;
         smp_cnt <= CNT_LOAD;
      end else begin
         case (state)
            ST_SEARCH: begin
               if (rx.i_en_rx) begin
                  if (smp_cnt == '0) state   <= ST_DECIDE;
                  else               smp_cnt <= smp_cnt - 1'b1;
               end
            end
            ST_DECIDE: begin
               o_phase  <= best_phase;
               o_locked <= 1'b1;
               state    <= ST_LOCKED;
            end
            default: ;
         endcase
      end
   end
`else
   logic unused_inputs;

   assign unused_inputs = ^{i_restart, rx.i_sample_I[NB_SAMPLE-2:0],
                            rx.i_sample_Q[NB_SAMPLE-2:0]};

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         o_phase  <= '0;
         o_locked <= 1'b0;
      end else begin
         o_phase  <= i_phase_sel;
         o_locked <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rx_symbol_slicer.sv
module tb_rx_symbol_slicer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       restart;
   logic [1:0] phase_sel;
   logic [1:0] o_phase;
   logic       o_locked;

   int errors = 0;
   int checks = 0;

   // Reference state: sample-phase counter, phase in force, held bits.
   logic [1:0] m_cnt, prev_phase, exp_phase;
   logic       exp_bi, exp_bq, exp_locked;
   int         strobes;
   logic [8:0] lfsr = 9'h1FF;

   always #5 clk = ~clk;

   rx_symbol_slicer_if #(.NB_SAMPLE(8)) rx_if ();

   rx_symbol_slicer #(
      .NB_SAMPLE (8),
      .OS        (4),
      .NB_PHASE  (2),
      .WINDOW    (16)
   ) dut (
      .clk         (clk),
      .i_reset     (rst_n),
      .rx          (rx_if),
      .i_restart   (restart),
      .i_phase_sel (phase_sel),
      .o_phase     (o_phase),
      .o_locked    (o_locked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic prbs();
      logic b;
      b    = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], b};
      return b;
   endfunction

   // One clock: drive inputs after a falling edge, check after the next one.
   task automatic cyc(input logic en, input logic [7:0] si, input logic [7:0] sq);
      logic fire;
      rx_if.i_en_rx    = en;
      rx_if.i_sample_I = si;
      rx_if.i_sample_Q = sq;
      fire = en && (m_cnt == prev_phase);
      @(negedge clk);
      if (en) m_cnt = m_cnt + 2'd1;
      if (fire) begin
         exp_bi = si[7];
         exp_bq = sq[7];
         strobes++;
      end
      chk("strobe", 32'(rx_if.o_en_rate1), 32'(fire));
      chk("bit_i", 32'(rx_if.o_rx_bit_I), 32'(exp_bi));
      chk("bit_q", 32'(rx_if.o_rx_bit_Q), 32'(exp_bq));
      chk("phase", 32'(o_phase), 32'(exp_phase));
      chk("locked", 32'(o_locked), 32'(exp_locked));
      prev_phase = exp_phase;
   endtask

   // Enabled samples with per-phase amplitude and PRBS9 signs.
   task automatic run_eye(input int a0, input int a1, input int a2, input int a3, input int n);
      int amp [4];
      int ai;
      logic [7:0] si, sq;
      amp = '{a0, a1, a2, a3};
      for (int k = 0; k < n; k++) begin
         ai = amp[m_cnt];
         si = prbs() ? 8'(-ai) : 8'(ai);
         sq = prbs() ? 8'(-ai) : 8'(ai);
         cyc(1'b1, si, sq);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      restart    = 1'b0;
      phase_sel  = 2'd0;
      m_cnt      = 2'd0;
      prev_phase = 2'd0;
      exp_phase  = 2'd0;
      exp_bi     = 1'b0;
      exp_bq     = 1'b0;
      exp_locked = 1'b0;
      strobes    = 0;

      // Reset held with live random samples.
      for (int k = 0; k < 4; k++) begin
         rx_if.i_en_rx    = 1'b1;
         rx_if.i_sample_I = 8'($urandom);
         rx_if.i_sample_Q = 8'($urandom);
         @(negedge clk);
      end
      chk("rst_bit_i", 32'(rx_if.o_rx_bit_I), 32'd0);
      chk("rst_bit_q", 32'(rx_if.o_rx_bit_Q), 32'd0);
      chk("rst_strobe", 32'(rx_if.o_en_rate1), 32'd0);
      chk("rst_phase", 32'(o_phase), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);

      rx_if.i_en_rx = 1'b0;
      rst_n = 1'b1;

`ifdef RX_PHASE_SEARCH_EN
      phase_sel  = 2'd3;
      exp_locked = 1'b0;
      cyc(1'b0, 8'd0, 8'd0);

      // Eye at phase 2: 64 samples of search, then DECIDE.
      run_eye(10, 10, 100, 10, 64);
      exp_phase  = 2'd2;
      exp_locked = 1'b1;
      cyc(1'b0, 8'd0, 8'd0);
      strobes = 0;
      run_eye(10, 10, 100, 10, 32);
      chk("eye_strobes", 32'(strobes), 32'd8);

      // Eye moves to phase 0; old phase holds for the whole re-search.
      restart = 1'b1;
      cyc(1'b0, 8'd0, 8'd0);
      restart = 1'b0;
      run_eye(100, 10, 10, 10, 64);
      exp_phase = 2'd0;
      cyc(1'b0, 8'd0, 8'd0);
      run_eye(100, 10, 10, 10, 16);

      // Partial search on phase 3 is discarded by a restart, then a tie 1/3.
      restart = 1'b1;
      cyc(1'b0, 8'd0, 8'd0);
      restart = 1'b0;
      run_eye(0, 0, 0, 100, 20);
      restart = 1'b1;
      cyc(1'b0, 8'd0, 8'd0);
      restart = 1'b0;
      run_eye(0, 80, 0, 80, 64);
      exp_phase = 2'd1;
      cyc(1'b0, 8'd0, 8'd0);
      run_eye(0, 80, 0, 80, 8);

      // Full-scale negative on every phase: equal sums, lowest index wins.
      restart = 1'b1;
      cyc(1'b0, 8'd0, 8'd0);
      restart = 1'b0;
      for (int k = 0; k < 64; k++) cyc(1'b1, 8'h80, 8'h80);
      exp_phase = 2'd0;
      cyc(1'b0, 8'd0, 8'd0);
      for (int k = 0; k < 8; k++) cyc(1'b1, 8'h80, 8'h80);
      chk("ext_bit_i", 32'(rx_if.o_rx_bit_I), 32'd1);
      chk("ext_bit_q", 32'(rx_if.o_rx_bit_Q), 32'd1);
`else
      exp_locked = 1'b1;
      cyc(1'b0, 8'h55, 8'hAA);
      cyc(1'b0, 8'h81, 8'h81);

      // Manual phase 0: slices samples 0 and 4.
      cyc(1'b1, 8'hFB, 8'h07);
      cyc(1'b1, 8'h01, 8'h01);
      cyc(1'b1, 8'h02, 8'h82);
      cyc(1'b1, 8'h83, 8'h03);
      cyc(1'b1, 8'h64, 8'h9C);
      cyc(1'b1, 8'hFF, 8'hFF);
      cyc(1'b1, 8'h00, 8'h00);
      cyc(1'b1, 8'h00, 8'h00);
      chk("p0_bit_i", 32'(rx_if.o_rx_bit_I), 32'd0);
      chk("p0_bit_q", 32'(rx_if.o_rx_bit_Q), 32'd1);

      // Manual phase 3 registered one cycle later.
      phase_sel = 2'd3;
      exp_phase = 2'd3;
      cyc(1'b0, 8'd0, 8'd0);

      // Gapped enable, one enabled cycle out of three; restart is inert.
      strobes = 0;
      restart = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 8'(k * 23 - 120), 8'(100 - k * 19));
         cyc(1'b0, 8'hC0, 8'h40);
         cyc(1'b0, 8'h40, 8'hC0);
      end
      restart = 1'b0;
      chk("gap_strobes", 32'(strobes), 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_symbol_slicer.md
# rx_symbol_slicer

Receive-side symbol-timing and decision stage that sits directly upstream of the BER checker. It takes oversampled, matched-filtered I/Q samples and picks one sampling phase per symbol, using a max-energy search over a symbol window. It slices that phase to hard bits and emits them with a one-cycle symbol-rate strobe. The outputs drive the BER checker's `i_rx_bit_I`, `i_rx_bit_Q` and `i_en_rate1` inputs directly.

## Interface
- `NB_SAMPLE`, 8: width of signed I/Q samples (two's complement).
- `OS`, 4: samples per symbol (≥2).
- `NB_PHASE`, 2: width of phase index, equal to clog2(OS).
- `WINDOW`, 1024: symbols accumulated per phase search (power of two).
- `clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_en_rx`  in  1  sample-rate clock enable; one input sample pair per asserted cycle.
- `i_sample_I`  in  NB_SAMPLE  signed in-phase sample.
- `i_sample_Q`  in  NB_SAMPLE  signed quadrature sample.
- `i_restart`  in  1  single-cycle pulse that restarts the phase search.
- `i_phase_sel`  in  NB_PHASE  manual phase; used only when search is compiled out.
- `o_rx_bit_I`  out  1  sliced in-phase bit.
- `o_rx_bit_Q`  out  1  sliced quadrature bit.
- `o_en_rate1`  out  1  one-cycle strobe marking a new bit pair.
- `o_phase`  out  NB_PHASE  phase currently used for slicing.
- `o_locked`  out  1  high once a search has completed.

## Operation
- **Phase counter**
  - Increments on each `i_en_rx`.
  - Wraps from OS-1 to 0.
  - Free-running; never stalled by the FSM.
- **Slicer**
  - Bit = sample MSB (negative → 1, zero/positive → 0).
  - This matches the 0→+1, 1→−1 mapping.
- **Energy metric**
  - Per sample: e = |I| + |Q|, unsigned, NB_SAMPLE+1 bits.
  - |−2^(NB_SAMPLE−1)| = 2^(NB_SAMPLE−1) exactly, with no overflow.
- **Accumulators**
  - OS accumulators, each NB_SAMPLE+1+clog2(WINDOW) bits wide, so they cannot overflow.
  - Accumulator[k] adds e when the phase counter equals k.
- **FSM states:** IDLE, SEARCH, DECIDE, LOCKED.
  - IDLE → SEARCH: on the first cycle after reset release. Accumulators and symbol counter are cleared.
  - SEARCH: accumulates until the symbol counter (counts phase-counter wraps) reaches WINDOW, then goes to DECIDE.
  - DECIDE: one cycle. Selects the argmax over accumulators; ties go to the lowest index. Loads `o_phase`, sets `o_locked`, goes to LOCKED.
  - LOCKED: holds `o_phase`. `i_restart` returns to SEARCH with accumulators cleared.
- **Restart behaviour**
  - `i_restart` in SEARCH or DECIDE also restarts SEARCH (clear and recount).
  - `o_locked` remains at its previous value during a re-search.
  - `o_phase` keeps its old value until the next DECIDE.
- **Reset behaviour**
  - All outputs are 0 in reset: bits, strobe, `o_phase`, `o_locked`.
  - Phase counter, accumulators and FSM (IDLE) are also cleared.
  - Reset mid-search discards the partial sums.
- **Idle input:** `i_en_rx` low means there is no accumulation, no counter advance and no strobe.

## Timing
- Slicing event: cycle N has `i_en_rx`=1 and phase counter == `o_phase`.
  - At cycle N+1, `o_rx_bit_I/Q` show the slice of the cycle-N sample, and `o_en_rate1`=1 for exactly that cycle.
  - Bits hold between strobes.
- Strobe spacing: exactly OS asserted `i_en_rx` cycles apart while `o_phase` is stable.
- Phase update: `o_phase` changes in the cycle after DECIDE.
  - The next strobe uses the new phase.
  - Across the change, the spacing may be shorter or longer than OS; the strobe is never doubled within a cycle.
- Search duration: WINDOW×OS asserted `i_en_rx` cycles from entering SEARCH, plus 1 DECIDE cycle.
- `o_locked` rises in the same cycle `o_phase` is first loaded.

## Configuration
- `RX_PHASE_SEARCH_EN` defined: the FSM, energy metric and accumulators are built as above; `i_phase_sel` is ignored.
- Not defined:
  - No search logic is built.
  - `o_phase` registers `i_phase_sel` every cycle (1-cycle latency, reset value 0).
  - `o_locked` = 1 from the first cycle after reset release.
  - `i_restart` is ignored.

## Structure
- Shared package `rx_pkg`:
  - FSM state encoding (IDLE, SEARCH, DECIDE, LOCKED).
  - Default NB_SAMPLE/OS/WINDOW constants.
  - Accumulator width function.
- Sub-module `rx_phase_energy`: OS accumulators plus argmax comparator. It has inputs clear/enable/phase/e and outputs best phase. It is instantiated only under `RX_PHASE_SEARCH_EN`.

## Test plan
- Reset: hold `i_reset`=0 with random samples → all outputs 0; release → no strobe before the first sample at phase 0.
- Eye at phase 2:
  - Stimulus: OS=4, WINDOW=16; phase 2 = ±100, other phases = ±10; random PRBS9 signs.
  - Required: after 64 `i_en_rx` cycles + 1, `o_phase`=2, `o_locked`=1; then sliced bits equal the PRBS sign of phase-2 samples.
- Tie:
  - Stimulus: phases 1 and 3 both ±80, others 0.
  - Required: `o_phase`=1.
- Extremes:
  - Stimulus: all samples −128, WINDOW=1024.
  - Required: no accumulator overflow (sum 262144 per phase); bits all 1; `o_phase`=0.
- Restart:
  - Stimulus: lock on phase 2, then move the eye to phase 0 and pulse `i_restart`.
  - Required: `o_phase` stays 2 for 64 samples, then becomes 0; `o_locked` never drops.
- Gapped enable and build without `RX_PHASE_SEARCH_EN`:
  - Stimulus: `i_en_rx` 1 of 3 cycles.
  - Required: strobe every 4 enabled samples, 1-cycle wide; `o_phase` follows `i_phase_sel`=3 one cycle later.
